uart_rx_ovs: RTL and testbench



---
 rtl/uart_rx_ovs_if.sv | 18 +
 rtl/uart_rx_ovs.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ovs_if.sv
// Read-side bundle of the oversampling UART receiver: FIFO head word, its error tags and the
// valid/ready pop handshake.
//   rx_d_o       head data, right-justified, zero-extended
//   rx_err_o     head tags {frame_err, parity_err}
//   rx_d_valid_o FIFO not empty
//   rx_d_ready_i consumer pops the head
// master: the receiver; slave: the register/DMA reader.
interface uart_rx_ovs_if #(
  parameter int unsigned DATA_W = 9
);
  logic [DATA_W-1:0] rx_d_o;
  logic [1:0]        rx_err_o;
  logic              rx_d_valid_o;
  logic              rx_d_ready_i;

  modport master (output rx_d_o, output rx_err_o, output rx_d_valid_o, input rx_d_ready_i);
  modport slave  (input rx_d_o, input rx_err_o, input rx_d_valid_o, output rx_d_ready_i);
endinterface

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver in the system clock domain. A baud tick generator paces a phase
// counter. Each bit is resolved by a 3-sample majority vote around mid-bit. Received words enter
// a first-word fall-through FIFO, tagged with their frame/parity errors.
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   rx_i                 asynchronous serial line, idle high
//   en_i                 receiver enable
//   baud_div_i           clk cycles per oversample tick (0 acts as 1)
//   data_bits_i          data bits per frame, clamped to 5..DATA_W
//   parity_en_i/_odd_i   parity enable / odd select
//   dstop_i              two stop bits
//   flush_i              synchronous FIFO clear
//   rd                   FIFO read port (uart_rx_ovs_if.master)
//   rts_n_o              0 while the FIFO has more than RTS_MARGIN free entries
//   overrun_o, break_o   one-cycle event pulses
//   fifo_cnt_o           FIFO occupancy
//   wakeup_o             FSM busy with a frame
module uart_rx_ovs #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned OVS        = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RTS_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          en_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [3:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          dstop_i,
  input  logic                          flush_i,
  uart_rx_ovs_if.master                 rd,
  output logic                          rts_n_o,
  output logic                          overrun_o,
  output logic                          break_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          wakeup_o
);
  localparam int unsigned PH_W  = $clog2(OVS);
  localparam int unsigned BC_W  = $clog2(DATA_W + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned WW    = DATA_W + 2;
  localparam logic [PH_W-1:0] PhS0  = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0] PhS1  = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0] PhRes = PH_W'(OVS / 2 + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDstop, StBreak} state_e;

  // Input synchroniser, idles high so reset never looks like a start bit.
  logic rx_meta_q, rxs_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  // Baud tick generator.
  logic [DIV_W-1:0] tick_cnt_q, reload;
  logic             tick;
  assign reload = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
  assign tick   = en_i && (tick_cnt_q == '0);
  always_ff @(posedge clk) begin
    if (!rst_n)              tick_cnt_q <= '0;
    else if (!en_i || tick)  tick_cnt_q <= reload;
    else                     tick_cnt_q <= tick_cnt_q - DIV_W'(1);
  end

  state_e state_q, state_d;
  logic   start_det;
  assign start_det = (state_q == StIdle) && en_i && !rxs_q;

  // Phase counter and vote samples; phase 0 is aligned to the detected falling edge.
  logic [PH_W-1:0] ph_q;
  logic            s0_q, s1_q, vote, vote_now;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_q <= '0;
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (start_det)  ph_q <= '0;
      else if (tick)  ph_q <= ph_q + PH_W'(1);
      if (tick && ph_q == PhS0) s0_q <= rxs_q;
      if (tick && ph_q == PhS1) s1_q <= rxs_q;
    end
  end
  assign vote     = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign vote_now = tick && (ph_q == PhRes);

  // Frame configuration, frozen for the whole frame.
  logic [BC_W-1:0] nbits_clamp, nbits_q;
  logic            par_en_q, par_odd_q, dstop_q;
  always_comb begin
    if (data_bits_i < 4'd5)                nbits_clamp = BC_W'(5);
    else if (32'(data_bits_i) > DATA_W)    nbits_clamp = BC_W'(DATA_W);
    else                                   nbits_clamp = BC_W'(data_bits_i);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nbits_q   <= BC_W'(5);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      dstop_q   <= 1'b0;
    end else if (start_det) begin
      nbits_q   <= nbits_clamp;
      par_en_q  <= parity_en_i;
      par_odd_q <= parity_odd_i;
      dstop_q   <= dstop_i;
    end
  end

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              par_err_q, par_err_d, par_bit_q, par_bit_d;
  logic              push_q, push_d, brk_q, brk_d;
  logic [WW-1:0]     push_word_q, push_word_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_err_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_err_q   <= par_err_d;
      par_bit_q   <= par_bit_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      brk_q       <= brk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_err_d   = par_err_q;
    par_bit_d   = par_bit_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    brk_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_det) begin
          state_d   = StStart;
          shift_d   = '0;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          par_bit_d = 1'b0;
        end
      end
      StStart: if (vote_now) state_d = vote ? StIdle : StData;
      StData: begin
        if (vote_now) begin
          shift_d   = shift_q | (DATA_W'(vote) << bit_cnt_q);
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == nbits_q - BC_W'(1)) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (vote_now) begin
          par_bit_d = vote;
          par_err_d = (^shift_q) ^ vote ^ par_odd_q;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (vote_now) begin
          if (vote && dstop_q) begin
            // Push waits for the second stop sample so it can carry frame_err.
            state_d = StDstop;
          end else if (!vote && shift_q == '0 && !par_bit_q) begin
            brk_d   = 1'b1;
            state_d = StBreak;
          end else begin
            push_d      = 1'b1;
            push_word_d = {~vote, par_err_q, shift_q};
            state_d     = StIdle;
          end
        end
      end
      StDstop: begin
        if (vote_now) begin
          push_d      = 1'b1;
          push_word_d = {~vote, par_err_q, shift_q};
          state_d     = StIdle;
        end
      end
      StBreak: if (rxs_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!en_i) state_d = StIdle;
  end

  // Receive FIFO, first-word fall-through.
  logic [WW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WW-1:0]    head;
  logic             full, pop, wr_ok, overrun_q, rts_q;

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop   = (cnt_q != '0) && rd.rx_d_ready_i;
  // A simultaneous pop frees the slot the push needs.
  assign wr_ok = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok && !flush_i) mem[wptr_q] <= push_word_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      rts_q     <= 1'b1;
    end else begin
      rts_q <= ~(en_i && ((CNT_W'(FIFO_DEPTH) - cnt_q) > CNT_W'(RTS_MARGIN)));
      if (flush_i) begin
        wptr_q    <= '0;
        rptr_q    <= '0;
        cnt_q     <= '0;
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= push_q && !wr_ok;
        if (wr_ok) wptr_q <= wptr_q + AW'(1);
        if (pop)   rptr_q <= rptr_q + AW'(1);
        case ({wr_ok, pop})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign head            = mem[rptr_q];
  assign rd.rx_d_valid_o = (cnt_q != '0);
  assign rd.rx_d_o       = rd.rx_d_valid_o ? head[DATA_W-1:0] : '0;
  assign rd.rx_err_o     = rd.rx_d_valid_o ? head[WW-1:WW-2] : 2'b00;
  assign fifo_cnt_o      = cnt_q;
  assign overrun_o       = overrun_q;
  assign break_o         = brk_q;
  assign rts_n_o         = rts_q;
  assign wakeup_o        = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_ovs.sv
module tb_uart_rx_ovs;
  localparam int BIT = 64;  // OVS 16 x baud_div 4

  logic        clk = 1'b0;
  logic        rst_n, rx_i, en_i, parity_en, parity_odd, dstop, flush;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic        rts_n, overrun, brk, wakeup;
  logic [3:0]  fifo_cnt;

  uart_rx_ovs_if #(.DATA_W(9)) rif ();

  uart_rx_ovs #(
    .DATA_W(9), .OVS(16), .DIV_W(16), .FIFO_DEPTH(8), .RTS_MARGIN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .en_i(en_i), .baud_div_i(baud_div),
    .data_bits_i(data_bits), .parity_en_i(parity_en), .parity_odd_i(parity_odd),
    .dstop_i(dstop), .flush_i(flush), .rd(rif), .rts_n_o(rts_n), .overrun_o(overrun),
    .break_o(brk), .fifo_cnt_o(fifo_cnt), .wakeup_o(wakeup)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int cyc = 0;
  int rise_cyc = 0;
  logic vprev = 1'b0;
  logic [10:0] sb[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    vprev <= rif.rx_d_valid_o;
    if (rif.rx_d_valid_o && !vprev) rise_cyc <= cyc;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (brk) brk_cnt <= brk_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    rx_i = b;
    if (glitch) begin
      repeat (30) @(negedge clk);
      rx_i = ~b;
      repeat (4) @(negedge clk);
      rx_i = b;
      repeat (BIT - 34) @(negedge clk);
    end else begin
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic idle(input int nbits);
    rx_i = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit pe, input bit po,
                            input bit pflip, input bit two_stop, input bit s2, input int gbit);
    logic p;
    data_bits  = 4'(nb);
    parity_en  = pe;
    parity_odd = po;
    dstop      = two_stop;
    p = po ^ pflip;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) begin
      p = p ^ d[i];
      drive_bit(d[i], i == gbit);
    end
    if (pe) drive_bit(p, 1'b0);
    drive_bit(1'b1, 1'b0);
    if (two_stop) drive_bit(s2, 1'b0);
    rx_i = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [10:0] exp;
    int n = 0;
    while (!rif.rx_d_valid_o && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!rif.rx_d_valid_o) begin
      check({tag, "_timeout"}, 32'(rif.rx_d_valid_o), 1);
    end else begin
      exp = sb.pop_front();
      check(tag, 32'({rif.rx_err_o, rif.rx_d_o}), 32'(exp));
      rif.rx_d_ready_i = 1'b1;
      @(negedge clk);
      rif.rx_d_ready_i = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d"}, 32'(rif.rx_d_o), 0);
    check({tag, "_err"}, 32'(rif.rx_err_o), 0);
    check({tag, "_valid"}, 32'(rif.rx_d_valid_o), 0);
    check({tag, "_cnt"}, 32'(fifo_cnt), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
    check({tag, "_brk"}, 32'(brk), 0);
    check({tag, "_wake"}, 32'(wakeup), 0);
    check({tag, "_rts"}, 32'(rts_n), 1);
  endtask

  initial begin
    int t0, o0, b0;
    rst_n = 1'b0; en_i = 1'b1; rx_i = 1'b1; baud_div = 16'd4; data_bits = 4'd8;
    parity_en = 1'b0; parity_odd = 1'b0; dstop = 1'b0; flush = 1'b0;
    rif.rx_d_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rts_empty", 32'(rts_n), 0);

    // 8N1 0xA5. The word is pushed right after the mid-stop vote, i.e. ~9.6 bit times after
    // the start edge, so the window runs from 9.4 bit times to a full frame plus one tick.
    t0 = cyc;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    sb.push_back({2'b00, 9'h0A5});
    idle(1);
    check("lat_8n1", 32'((rise_cyc - t0) >= 600 && (rise_cyc - t0) <= 644), 1);
    pop_check("8n1_a5");

    // 7O2: wrong parity, then good parity with a low second stop.
    send_frame(9'h03C, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    sb.push_back({2'b01, 9'h03C});
    idle(2);
    pop_check("7o2_par");
    send_frame(9'h03C, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    sb.push_back({2'b10, 9'h03C});
    idle(2);
    pop_check("7o2_frm");

    // False start: 4-tick low glitch.
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    idle(2);
    check("fs_cnt", 32'(fifo_cnt), 0);
    check("fs_valid", 32'(rif.rx_d_valid_o), 0);
    check("fs_wake", 32'(wakeup), 0);
    // 9N1 0x1FF with a one-tick low glitch in bit 3.
    send_frame(9'h1FF, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    sb.push_back({2'b00, 9'h1FF});
    idle(1);
    pop_check("9n1_glitch");

    // Overrun and RTS with the reader stalled.
    o0 = ovr_cnt;
    for (int v = 1; v <= 9; v++) begin
      send_frame(9'(v), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      if (v <= 8) sb.push_back({2'b00, 9'(v)});
      idle(1);
      if (v == 5) begin
        check("cnt5", 32'(fifo_cnt), 5);
        check("rts_cnt5", 32'(rts_n), 0);
      end
      if (v == 6) begin
        check("cnt6", 32'(fifo_cnt), 6);
        check("rts_cnt6", 32'(rts_n), 1);
      end
    end
    check("ovr_pulse", 32'(ovr_cnt - o0), 1);
    check("cnt_full", 32'(fifo_cnt), 8);
    for (int i = 0; i < 8; i++) pop_check("ovr_pop");
    check("cnt_drained", 32'(fifo_cnt), 0);

    // Break: line low for 3 frame times, then a normal 0x55.
    b0 = brk_cnt;
    data_bits = 4'd8; parity_en = 1'b0; dstop = 1'b0;
    rx_i = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    idle(2);
    check("brk_pulse", 32'(brk_cnt - b0), 1);
    check("brk_nopush", 32'(fifo_cnt), 0);
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    sb.push_back({2'b00, 9'h055});
    idle(1);
    pop_check("after_brk");

    // Flush held across the push of the second word; both words gone, no overrun.
    o0 = ovr_cnt;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(1);
    check("pre_flush_cnt", 32'(fifo_cnt), 1);
    fork
      send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      begin
        repeat (9 * BIT) @(negedge clk);
        flush = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        flush = 1'b0;
      end
    join
    idle(1);
    check("flush_cnt", 32'(fifo_cnt), 0);
    check("flush_valid", 32'(rif.rx_d_valid_o), 0);
    check("flush_ovr", 32'(ovr_cnt - o0), 0);

    // Reset pulse in the middle of the data bits of 0x5A.
    data_bits = 4'd8;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    check("mid_wake", 32'(wakeup), 1);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    idle(12);
    check("midrst_cnt", 32'(fifo_cnt), 0);
    check("midrst_valid", 32'(rif.rx_d_valid_o), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
